// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive path (and a future transmitter).
//   rx_state_t           : receiver FSM states
//   DEFAULT_CLKS_PER_BIT : 50 MHz / 9600 baud
//   UART_DATA_BITS       : data bits per frame (8N1)
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk : sampling clock
//   rst : synchronous active-high reset, loads RST_VAL into both flops
//   d   : asynchronous input
//   q   : synchronized output (two clocks of latency)
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, oversampled by the system clock.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   rx        : asynchronous serial line, idles high
//   datarx    : last good byte, held until the next good frame
//   rx_done   : one-cycle pulse when datarx is updated
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   busy      : high whenever the FSM is not in IDLE (including WAIT_HIGH)
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] datarx,
  output logic                      rx_done,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  rx_state_t                 state;
  rx_state_t                 state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      bit_end;
  logic                      half_end;

  // Input synchronizer: idles high so reset never looks like a start edge
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign half_end = (cnt == HALF_M1);
  assign bit_end  = (cnt == FULL_M1);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_HIGH: if (rx_s) state_nxt = IDLE;
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (half_end) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (bit_end && bit_idx == LAST_BIT) state_nxt = STOP;
      // A low stop bit may be a break: wait for the line to go high again
      STOP:      if (bit_end) state_nxt = rx_s ? IDLE : WAIT_HIGH;
      default:   state_nxt = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_HIGH;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      datarx    <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        START: begin
          // Counting from the detected edge, half a bit lands mid start bit
          if (half_end) begin
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (rx_s) begin
              datarx  <= shreg;
              rx_done <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

  localparam int CPB = 16;
  // Line fall (driven on a negedge) -> 3 clocks to T0, then half a bit
  // plus nine bits to the stop sample; the strobe is seen in that next cycle.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] datarx;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] done_q[$];
  int         done_cyc[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .datarx    (datarx),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: every high cycle of a strobe is logged
  always @(negedge clk) begin
    if (rx_done) begin
      done_q.push_back(datarx);
      done_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_done && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int c);
    c = cyc;
    drive(1'b0, CPB);
    for (int k = 0; k < 8; k++) drive(b[k], CPB);
    drive(stop, CPB);
  endtask

  task automatic send_skewed(input logic [7:0] b, output int c);
    int   bnd[11];
    logic lv[10];
    lv[0] = 1'b0;
    for (int k = 0; k < 8; k++) lv[k+1] = b[k];
    lv[9] = 1'b1;
    bnd[0]  = 0;
    bnd[10] = 10 * CPB;
    for (int i = 1; i < 10; i++) bnd[i] = i * CPB + int'($urandom_range(0, 6)) - 3;
    c = cyc;
    for (int i = 0; i < 10; i++) drive(lv[i], bnd[i+1] - bnd[i]);
  endtask

  task automatic test_reset();
    total++; if (datarx !== 8'h00) begin bad++; $display("FAIL reset_datarx: got %h want 00", datarx); end
    total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    idle(2);
    rst = 1'b0;
    idle(5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_good_frame();
    int n0, f0, c;
    n0 = done_q.size(); f0 = ferr_cnt;
    send_frame(8'h47, 1'b1, c);
    idle(5);
    last_good = 8'h47;
    total++;
    if (done_q.size() !== n0 + 1) begin
      bad++; $display("FAIL good_count: got %0d want 1", done_q.size() - n0);
    end else begin
      total++; if (done_q[n0] !== 8'h47) begin bad++; $display("FAIL good_byte: got %h want 47", done_q[n0]); end
      total++; if (done_cyc[n0] !== c + LAT) begin bad++; $display("FAIL good_timing: got %0d want %0d", done_cyc[n0] - c, LAT); end
    end
    total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL good_ferr: got %0d want 0", ferr_cnt - f0); end
    total++; if (datarx !== 8'h47) begin bad++; $display("FAIL good_hold: got %h want 47", datarx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals[3] = '{8'h43, 8'h70, 8'h55};
    int c[3];
    int n0;
    n0 = done_q.size();
    for (int i = 0; i < 3; i++) send_frame(vals[i], 1'b1, c[i]);
    idle(5);
    last_good = 8'h55;
    total++;
    if (done_q.size() !== n0 + 3) begin
      bad++; $display("FAIL b2b_count: got %0d want 3", done_q.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++; if (done_q[n0+i] !== vals[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, done_q[n0+i], vals[i]); end
        total++; if (done_cyc[n0+i] !== c[i] + LAT) begin bad++; $display("FAIL b2b_timing%0d: got %0d want %0d", i, done_cyc[n0+i] - c[i], LAT); end
      end
    end
  endtask

  task automatic test_frame_error();
    int n0, f0, c;
    n0 = done_q.size(); f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0, c);
    drive(1'b0, 40);
    total++; if (ferr_cnt !== f0 + 1) begin bad++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    total++; if (datarx !== last_good) begin bad++; $display("FAIL ferr_hold: got %h want %h", datarx, last_good); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_wait_busy: got %b want 1", busy); end
    drive(1'b1, 12 * CPB);
    total++; if (done_q.size() !== n0) begin bad++; $display("FAIL ferr_no_done: got %0d want 0", done_q.size() - n0); end
    total++; if (ferr_cnt !== f0 + 1) begin bad++; $display("FAIL ferr_single: got %0d want 1", ferr_cnt - f0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_idle: got %b want 0", busy); end
    send_frame(8'h52, 1'b1, c);
    idle(5);
    last_good = 8'h52;
    total++; if (done_q.size() !== n0 + 1) begin bad++; $display("FAIL ferr_next_count: got %0d want 1", done_q.size() - n0); end
    total++; if (datarx !== 8'h52) begin bad++; $display("FAIL ferr_next_byte: got %h want 52", datarx); end
  endtask

  task automatic test_glitch();
    int n0, f0;
    n0 = done_q.size(); f0 = ferr_cnt;
    rx = 1'b0;
    idle(3);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_seen: got %b want 1", busy); end
    idle(2);
    rx = 1'b1;
    idle(6);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
    idle(12 * CPB);
    total++; if (done_q.size() !== n0) begin bad++; $display("FAIL glitch_done: got %0d want 0", done_q.size() - n0); end
    total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_reset_mid_frame();
    int n0, f0, c;
    n0 = done_q.size(); f0 = ferr_cnt;
    drive(1'b0, CPB);
    drive(1'b1, 3 * CPB);
    rx = 1'b0;
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    last_good = 8'h00;
    total++; if (datarx !== 8'h00) begin bad++; $display("FAIL rstmid_datarx: got %h want 00", datarx); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy: got %b want 1", busy); end
    idle(1);
    drive(1'b1, 6 * CPB);
    idle(6 * CPB);
    total++; if (done_q.size() !== n0) begin bad++; $display("FAIL rstmid_done: got %0d want 0", done_q.size() - n0); end
    total++; if (ferr_cnt !== f0) begin bad++; $display("FAIL rstmid_ferr: got %0d want 0", ferr_cnt - f0); end
    total++; if (datarx !== 8'h00) begin bad++; $display("FAIL rstmid_cleared: got %h want 00", datarx); end
    send_frame(8'h67, 1'b1, c);
    idle(5);
    last_good = 8'h67;
    total++; if (done_q.size() !== n0 + 1) begin bad++; $display("FAIL rstmid_next_count: got %0d want 1", done_q.size() - n0); end
    total++; if (datarx !== 8'h67) begin bad++; $display("FAIL rstmid_next_byte: got %h want 67", datarx); end
  endtask

  task automatic test_skew();
    int n0, c;
    for (int r = 0; r < 3; r++) begin
      n0 = done_q.size();
      send_skewed(8'h75, c);
      idle(4);
      last_good = 8'h75;
      total++;
      if (done_q.size() !== n0 + 1) begin
        bad++; $display("FAIL skew%0d_count: got %0d want 1", r, done_q.size() - n0);
      end else begin
        total++; if (done_q[n0] !== 8'h75) begin bad++; $display("FAIL skew%0d_byte: got %h want 75", r, done_q[n0]); end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    int n0, f0, c;
    for (int r = 0; r < 8; r++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      n0 = done_q.size(); f0 = ferr_cnt;
      send_frame(b, stop, c);
      drive(1'b1, int'($urandom_range(4, 20)));
      if (stop) last_good = b;
      total++; if (done_q.size() !== n0 + (stop ? 1 : 0)) begin bad++; $display("FAIL rand%0d_done: got %0d want %0d", r, done_q.size() - n0, stop ? 1 : 0); end
      total++; if (ferr_cnt !== f0 + (stop ? 0 : 1)) begin bad++; $display("FAIL rand%0d_ferr: got %0d want %0d", r, ferr_cnt - f0, stop ? 0 : 1); end
      total++; if (datarx !== last_good) begin bad++; $display("FAIL rand%0d_byte: got %h want %h", r, datarx, last_good); end
    end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobes_exclusive: got %0d want 0", both_cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_skew();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
